wb_sel_stage: RTL and testbench

Registered writeback-select stage for the RV32I core. It replaces the purely combinational writeback mux and sits between EX/MEM and the register file.
- Selects ALU result, PC+4, or load data by opcode.
- Aligns and sign/zero-extends sub-word loads.
- Stalls EX through a ready handshake while a load response is outstanding.
- Presents one registered register-file write per retired instruction.

---
 rtl/core_pkg.sv | 24 ++
 rtl/load_extend.sv | 37 +++
 rtl/wb_sel_stage.sv | 165 ++++++++++++++++
 tb/tb_wb_sel_stage.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: opcode classes, load funct3 encodings and the
// writeback-select stage state type.
package core_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {WB_IDLE, WB_WAIT_LOAD} wb_state_e;

  // Stores and branches retire without touching the register file.
  function automatic logic op_writes_rf(input logic [6:0] op);
    return (op != OP_STORE) && (op != OP_BRANCH);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data aligner / extender (combinational).
// Ports:
//   rdata  - raw aligned memory word
//   funct3 - load size/sign (LB/LH/LW/LBU/LHU, others treated as LW)
//   off    - byte offset within the word (load address [1:0])
//   ext    - aligned, sign- or zero-extended result
module load_extend
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] ext
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    word     = rdata[31:0];
    byte_sel = word[{off, 3'b000} +: 8];
    // Halfword loads use only off[1]; off[0] is ignored.
    half_sel = off[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_LB:   ext = XLEN'($signed(byte_sel));
      F3_LBU:  ext = XLEN'(byte_sel);
      F3_LH:   ext = XLEN'($signed(half_sel));
      F3_LHU:  ext = XLEN'(half_sel);
      default: ext = XLEN'($signed(word));
    endcase
  end

endmodule

// File: rtl/wb_sel_stage.sv
// Registered writeback-select stage between EX/MEM and the register file.
// Selects ALU result, PC+4 or extended load data and presents one registered
// register-file write per retired instruction. Loads hold ex_ready low until
// mem_rvalid returns.
// Optional: define WB_LOAD_TIMEOUT_EN to abandon a load after LOAD_TIMEOUT
// cycles without mem_rvalid (no write, one-cycle load_fault pulse).
// Ports:
//   clk, rst_n                 - clock, async active-low reset
//   ex_valid/ex_ready/flush    - EX handshake; flush kills the offered instr
//   ex_opcode/funct3/rd        - instruction decode fields
//   ex_alu_out, ex_pc_next     - ALU result (load address), link value
//   mem_rvalid, mem_rdata      - load response
//   wb_we, wb_rd, wb_data      - registered register-file write
//   load_fault                 - load timeout pulse
module wb_sel_stage
  import core_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RA_W         = 5,
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic            flush,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [RA_W-1:0] ex_rd,
  input  logic [XLEN-1:0] ex_alu_out,
  input  logic [XLEN-1:0] ex_pc_next,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_we,
  output logic [RA_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            load_fault
);

  wb_state_e       state_q, state_d;
  logic [RA_W-1:0] ld_rd_q, ld_rd_d;
  logic [2:0]      ld_f3_q, ld_f3_d;
  logic [1:0]      ld_off_q, ld_off_d;
  logic            wb_we_q, wb_we_d;
  logic [RA_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [XLEN-1:0] ld_ext;
  logic            accept;
  logic [XLEN-1:0] sel_data;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(LOAD_TIMEOUT + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;
`else
  logic unused_timeout;
  assign unused_timeout = (LOAD_TIMEOUT == 0);
`endif

  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata (mem_rdata),
    .funct3(ld_f3_q),
    .off   (ld_off_q),
    .ext   (ld_ext)
  );

  assign accept   = ex_valid & ex_ready & ~flush;
  assign sel_data = ((ex_opcode == OP_JAL) || (ex_opcode == OP_JALR)) ? ex_pc_next : ex_alu_out;

  always_comb begin
    state_d   = state_q;
    ld_rd_d   = ld_rd_q;
    ld_f3_d   = ld_f3_q;
    ld_off_d  = ld_off_q;
    wb_we_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    ex_ready  = (state_q == WB_IDLE);
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_d     = cnt_q;
    fault_d   = 1'b0;
`endif

    unique case (state_q)
      WB_IDLE: begin
        if (accept) begin
          if (ex_opcode == OP_LOAD) begin
            ld_rd_d  = ex_rd;
            ld_f3_d  = ex_funct3;
            ld_off_d = ex_alu_out[1:0];
            state_d  = WB_WAIT_LOAD;
`ifdef WB_LOAD_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end else begin
            wb_we_d   = op_writes_rf(ex_opcode) && (ex_rd != '0);
            wb_rd_d   = ex_rd;
            wb_data_d = sel_data;
          end
        end
      end
      WB_WAIT_LOAD: begin
        // flush is deliberately ignored here: an issued load always completes.
        if (mem_rvalid) begin
          wb_we_d   = (ld_rd_q != '0);
          wb_rd_d   = ld_rd_q;
          wb_data_d = ld_ext;
          state_d   = WB_IDLE;
        end
`ifdef WB_LOAD_TIMEOUT_EN
        else if (cnt_q == CntW'(LOAD_TIMEOUT - 1)) begin
          state_d = WB_IDLE;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= WB_IDLE;
      ld_rd_q   <= '0;
      ld_f3_q   <= '0;
      ld_off_q  <= '0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ld_rd_q   <= ld_rd_d;
      ld_f3_q   <= ld_f3_d;
      ld_off_q  <= ld_off_d;
      wb_we_q   <= wb_we_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign load_fault = fault_q;
`else
  assign load_fault = 1'b0;
`endif

  assign wb_we   = wb_we_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;

endmodule

// File: tb/tb_wb_sel_stage.sv
// Self-checking bench for wb_sel_stage: directed cases plus randomized traffic,
// with expected writes queued by a reference model and checked by a monitor.
module tb_wb_sel_stage;
  import core_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int LOAD_TIMEOUT = 16;

  logic            clk;
  logic            rst_n;
  logic            ex_valid;
  logic            ex_ready;
  logic            flush;
  logic [6:0]      ex_opcode;
  logic [2:0]      ex_funct3;
  logic [RA_W-1:0] ex_rd;
  logic [XLEN-1:0] ex_alu_out;
  logic [XLEN-1:0] ex_pc_next;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            wb_we;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            load_fault;

  wb_sel_stage #(
    .XLEN        (XLEN),
    .RA_W        (RA_W),
    .LOAD_TIMEOUT(LOAD_TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .flush     (flush),
    .ex_opcode (ex_opcode),
    .ex_funct3 (ex_funct3),
    .ex_rd     (ex_rd),
    .ex_alu_out(ex_alu_out),
    .ex_pc_next(ex_pc_next),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .load_fault(load_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_fail = 0;
  int  fault_seen = 0;
  int  exp_faults = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the register file should receive.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    case (f3)
      3'b000: begin
        v = (rdata >> (off * 8)) & 32'hFF;
        if (v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      3'b100: v = (rdata >> (off * 8)) & 32'hFF;
      3'b001: begin
        v = (rdata >> ((off / 2) * 16)) & 32'hFFFF;
        if (v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      3'b101: v = (rdata >> ((off / 2) * 16)) & 32'hFFFF;
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_sel(input logic [6:0] op, input logic [31:0] alu,
                                            input logic [31:0] pc);
    if (op == 7'b1101111 || op == 7'b1100111) return pc;
    return alu;
  endfunction

  function automatic bit model_writes(input logic [6:0] op);
    return !(op == 7'b0100011 || op == 7'b1100011);
  endfunction

  // Monitor: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (load_fault) fault_seen++;
      if (wb_we) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: rd=%0d data=%h, no write expected (t=%0t)",
                   wb_rd, wb_data, $time);
        end else begin
          mon_e = sb.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(mon_e.rd));
          check("wb_data", wb_data, mon_e.data);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one cycle (the stage is expected to be idle).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] pc, input bit fl,
                       input bit push);
    check("ex_ready_idle", 32'(ex_ready), 32'd1);
    ex_valid   = 1'b1;
    flush      = fl;
    ex_opcode  = op;
    ex_funct3  = f3;
    ex_rd      = rd;
    ex_alu_out = alu;
    ex_pc_next = pc;
    tick();
    ex_valid = 1'b0;
    flush    = 1'b0;
    if (push && !fl && op != OP_LOAD && model_writes(op) && rd != 5'd0) begin
      sb.push_back('{rd: rd, data: model_sel(op, alu, pc)});
    end
  endtask

  // Issue a load and return its response `delay` cycles after the accept.
  task automatic do_load(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                         input logic [31:0] rdata, input int delay, input bit wait_noise);
    if (rd != 5'd0) sb.push_back('{rd: rd, data: model_load(f3, addr[1:0], rdata)});
    // A response in the accept cycle must be ignored.
    mem_rvalid = wait_noise;
    mem_rdata  = $urandom;
    issue(OP_LOAD, f3, rd, addr, 32'($urandom), 1'b0, 1'b0);
    for (int k = 1; k <= delay; k++) begin
      check("ex_ready_wait", 32'(ex_ready), 32'd0);
      if (wait_noise) begin
        ex_valid   = 1'b1;
        flush      = 1'($urandom);
        ex_opcode  = 7'b0110011;
        ex_rd      = 5'($urandom);
        ex_alu_out = $urandom;
      end
      mem_rvalid = (k == delay);
      mem_rdata  = (k == delay) ? rdata : $urandom;
      tick();
    end
    mem_rvalid = 1'b0;
    ex_valid   = 1'b0;
    flush      = 1'b0;
    check("ex_ready_after_load", 32'(ex_ready), 32'd1);
  endtask

  logic [6:0] ops[8];

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0110111, OP_JAL, OP_JALR, OP_STORE, OP_BRANCH, OP_LOAD};
    rst_n      = 1'b0;
    ex_valid   = 1'b0;
    flush      = 1'b0;
    ex_opcode  = '0;
    ex_funct3  = '0;
    ex_rd      = '0;
    ex_alu_out = '0;
    ex_pc_next = '0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    #1;
    check("reset_wb_we", 32'(wb_we), 32'd0);
    check("reset_wb_rd", 32'(wb_rd), 32'd0);
    check("reset_wb_data", wb_data, 32'd0);
    check("reset_fault", 32'(load_fault), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check("ready_after_reset", 32'(ex_ready), 32'd1);

    // Basic select and back-to-back retire.
    issue(7'b0110011, 3'd0, 5'd5, 32'h0000_1234, 32'h0, 1'b0, 1'b1);
    issue(OP_JAL, 3'd0, 5'd1, 32'hDEAD_BEEF, 32'h100, 1'b0, 1'b1);
    issue(OP_JALR, 3'd0, 5'd2, 32'h1111_0000, 32'h204, 1'b0, 1'b1);
    tick();

    // Sub-word loads.
    do_load(F3_LB, 5'd6, 32'h0000_1003, 32'h8000_0000, 4, 1'b0);
    do_load(F3_LBU, 5'd7, 32'h0000_1003, 32'h8000_0000, 4, 1'b0);
    do_load(F3_LHU, 5'd8, 32'h0000_2002, 32'hBEEF_0000, 2, 1'b0);
    do_load(F3_LH, 5'd9, 32'h0000_2003, 32'hBEEF_0000, 1, 1'b0);
    do_load(F3_LW, 5'd10, 32'h0000_2001, 32'hCAFE_F00D, 3, 1'b0);

    // No-write cases and flush in idle.
    issue(OP_STORE, 3'd2, 5'd11, 32'h55, 32'h0, 1'b0, 1'b1);
    issue(7'b0110011, 3'd0, 5'd0, 32'h77, 32'h0, 1'b0, 1'b1);
    issue(7'b0110011, 3'd0, 5'd12, 32'h99, 32'h0, 1'b1, 1'b1);
    check("ready_after_flush", 32'(ex_ready), 32'd1);

    // Stray response while idle.
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check("ready_after_idle_rvalid", 32'(ex_ready), 32'd1);

    // Flush during the wait does not cancel the load.
    do_load(F3_LB, 5'd13, 32'h0000_0001, 32'h0000_7F00, 3, 1'b1);

    // Reset with a write on the outputs.
    issue(7'b0110011, 3'd0, 5'd14, 32'hABCD, 32'h0, 1'b0, 1'b0);
    check("we_before_reset", 32'(wb_we), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_wb_we", 32'(wb_we), 32'd0);
    check("midreset_wb_data", wb_data, 32'd0);
    tick();
    rst_n = 1'b1;
    check("ready_after_midreset", 32'(ex_ready), 32'd1);

    // Reset mid-load, then a late response must be ignored.
    issue(OP_LOAD, F3_LW, 5'd15, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    check("ready_in_load", 32'(ex_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("ready_load_reset", 32'(ex_ready), 32'd1);
    tick();
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;

`ifdef WB_LOAD_TIMEOUT_EN
    // Abandoned load: fault 16 cycles after accept, no write.
    issue(OP_LOAD, F3_LW, 5'd16, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= LOAD_TIMEOUT; k++) begin
      check("timeout_ready_low", 32'(ex_ready), 32'd0);
      check("timeout_no_early_fault", 32'(load_fault), 32'd0);
      tick();
    end
    check("timeout_fault", 32'(load_fault), 32'd1);
    check("timeout_ready", 32'(ex_ready), 32'd1);
    exp_faults++;
    tick();
    check("timeout_fault_pulse", 32'(load_fault), 32'd0);
    // Response on the timeout cycle wins.
    do_load(F3_LW, 5'd17, 32'h0, 32'h0BAD_CAFE, LOAD_TIMEOUT, 1'b0);
`else
    // Without the timeout the stage waits as long as needed.
    do_load(F3_LHU, 5'd17, 32'h2, 32'h1234_5678, 24, 1'b0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 7)];
      if (op == OP_LOAD) begin
        do_load(3'($urandom), 5'($urandom), $urandom, $urandom, $urandom_range(1, 5),
                1'($urandom));
      end else begin
        issue(op, 3'($urandom), 5'($urandom), $urandom, $urandom,
              ($urandom_range(0, 7) == 0), 1'b1);
      end
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'($urandom);
        mem_rdata  = $urandom;
        tick();
        mem_rvalid = 1'b0;
      end
    end

    tick();
    tick();
    tick();
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("fault_count", 32'(fault_seen), 32'(exp_faults));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
